// File: rtl/spdif_encode.sv
`default_nettype none
// ============================================================================
// Module   : spdif_encode
// Brief    : S/PDIF biphase-mark transmitter with one-pair holding register.
//            Define SPDIF_TX_CHSTAT_EN to send CHSTAT_WORD as channel status.
// Revision : 1.0  initial release
// ============================================================================
module spdif_encode #(
  parameter int          CLK_IN_FREQ = 38400000,
  parameter int          BMC_FREQ    = 3072000,
  parameter logic [31:0] CHSTAT_WORD = 32'h0200_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] sample_left,
  input  logic [23:0] sample_right,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        spdif,
  output logic        underrun,
  output logic        block_start
);

  localparam logic [32:0] c_step  = 33'(2 * BMC_FREQ);
  localparam logic [32:0] c_clk   = 33'(CLK_IN_FREQ);
  localparam logic [7:0]  c_pre_x = 8'b1110_0010;
  localparam logic [7:0]  c_pre_y = 8'b1110_0100;
  localparam logic [7:0]  c_pre_z = 8'b1110_1000;

  logic [31:0] acc_q, acc_d;
  logic [5:0]  hc_q, hc_d;
  logic        chan_q, chan_d;
  logic [7:0]  frame_q, frame_d;
  logic        spdif_q, spdif_d;
  logic        pol_q, pol_d;
  logic        underrun_q, underrun_d;
  logic        block_start_q, block_start_d;
  logic        ready_q, ready_d;
  logic        hold_full_q, hold_full_d;
  logic [23:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [23:0] left_q, left_d, right_q, right_d;
  logic        v_q, v_d;

  logic [32:0] sum;
  logic        tick, boundary, accept;
  logic [7:0]  pat;
  logic        pol, c_bit, line;
  logic [23:0] audio;
  logic [26:0] payload;
  logic [31:0] slot_vec;

  // Tick timing: the phase accumulator gives an exact long-run half-cell rate.
  always_comb begin
    sum      = {1'b0, acc_q} + c_step;
    tick     = (sum >= c_clk);
    acc_d    = tick ? 32'(sum - c_clk) : sum[31:0];
    boundary = tick && (hc_q == 6'd0) && !chan_q;
    accept   = sample_valid && ready_q;
    hc_d     = hc_q;
    chan_d   = chan_q;
    frame_d  = frame_q;
    if (tick) begin
      hc_d = hc_q + 6'd1;
      if (hc_q == 6'd63) begin
        chan_d = ~chan_q;
        if (chan_q) frame_d = (frame_q == 8'd191) ? 8'd0 : frame_q + 8'd1;
      end
    end
  end

  // A frame-boundary load reads the old holding contents, so an accept on the same edge is kept.
  always_comb begin
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    left_d      = left_q;
    right_d     = right_q;
    v_d         = v_q;
    if (boundary) begin
      left_d      = hold_full_q ? hold_l_q : 24'd0;
      right_d     = hold_full_q ? hold_r_q : 24'd0;
      v_d         = !hold_full_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_l_d    = sample_left;
      hold_r_d    = sample_right;
      hold_full_d = 1'b1;
    end
    ready_d       = !hold_full_d;
    underrun_d    = boundary && !hold_full_q;
    block_start_d = boundary && (frame_q == 8'd0);
  end

`ifdef SPDIF_TX_CHSTAT_EN
  always_comb c_bit = (frame_q < 8'd32) ? CHSTAT_WORD[frame_q[4:0]] : 1'b0;
`else
  localparam logic [31:0] c_chstat_unused = CHSTAT_WORD;
  always_comb c_bit = 1'b0;
`endif

  // Slot n of the subframe sits at bit n, so the half-cell count indexes it directly.
  always_comb begin
    audio    = chan_q ? right_q : left_q;
    payload  = {c_bit, 1'b0, v_q, audio};
    slot_vec = {^payload, payload, 4'b0000};
    pat      = chan_q ? c_pre_y : ((frame_q == 8'd0) ? c_pre_z : c_pre_x);
    pol      = (hc_q == 6'd0) ? spdif_q : pol_q;
    pol_d    = (tick && (hc_q == 6'd0)) ? spdif_q : pol_q;
    if (hc_q < 6'd8)      line = pat[~hc_q[2:0]] ^ pol;
    else if (!hc_q[0])    line = ~spdif_q;
    else                  line = spdif_q ^ slot_vec[hc_q[5:1]];
    spdif_d = tick ? line : spdif_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q         <= '0;
      hc_q          <= '0;
      chan_q        <= 1'b0;
      frame_q       <= '0;
      spdif_q       <= 1'b0;
      pol_q         <= 1'b0;
      underrun_q    <= 1'b0;
      block_start_q <= 1'b0;
      ready_q       <= 1'b0;
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      left_q        <= '0;
      right_q       <= '0;
      v_q           <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      hc_q          <= hc_d;
      chan_q        <= chan_d;
      frame_q       <= frame_d;
      spdif_q       <= spdif_d;
      pol_q         <= pol_d;
      underrun_q    <= underrun_d;
      block_start_q <= block_start_d;
      ready_q       <= ready_d;
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      left_q        <= left_d;
      right_q       <= right_d;
      v_q           <= v_d;
    end
  end

  assign sample_ready = ready_q;
  assign spdif        = spdif_q;
  assign underrun     = underrun_q;
  assign block_start  = block_start_q;

endmodule
`default_nettype wire

// File: tb/tb_spdif_encode.sv
`default_nettype none
// ============================================================================
// Module   : tb_spdif_encode
// Brief    : Scoreboard bench for spdif_encode: decodes the line per frame and
//            compares against pairs queued at each frame boundary.
// Revision : 1.0  initial release
// ============================================================================
module tb_spdif_encode;

  localparam int         CLKF = 10000000;
  localparam int         BMCF = 3000000;
  localparam logic [7:0] PX   = 8'b1110_0010;
  localparam logic [7:0] PY   = 8'b1110_0100;
  localparam logic [7:0] PZ   = 8'b1110_1000;

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
    logic        v;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] sample_left = '0;
  logic [23:0] sample_right = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready, spdif, underrun, block_start;

  int checks = 0;
  int errors = 0;

  spdif_encode #(.CLK_IN_FREQ(CLKF), .BMC_FREQ(BMCF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .spdif        (spdif),
    .underrun     (underrun),
    .block_start  (block_start)
  );

  always #5 clk = ~clk;

  longint      acc = 0;
  int          nxt = 0;
  int          fcnt = 0;
  int          cap_idx = 0;
  int          cap_frame = 0;
  int          frames_done = 0;
  bit          tick_prev = 0;
  bit          exp_ur = 0;
  bit          exp_bs = 0;
  logic        prev_lvl = 1'b0;
  logic        lev [0:127];
  logic [47:0] pending [$];
  frame_t      expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic decode_frame(input int fno);
    frame_t      e;
    logic        p, lvl, bad, cexp;
    logic [7:0]  got, pat;
    logic [27:0] w;
    int          b;
`ifdef SPDIF_TX_CHSTAT_EN
    logic [31:0] chw;
    chw = 32'h0200_0004;
`endif
    cexp = 1'b0;
`ifdef SPDIF_TX_CHSTAT_EN
    if ((fno % 192) < 32) cexp = chw[5'(fno % 192)];
`endif
    e = '0;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_queue: frame %0d decoded with no expected entry", fno);
    end else begin
      e = expq.pop_front();
    end
    p = prev_lvl;
    for (int ch = 0; ch < 2; ch++) begin
      b   = ch * 64;
      pat = (ch == 1) ? PY : (((fno % 192) == 0) ? PZ : PX);
      for (int i = 0; i < 8; i++) got[7-i] = lev[b+i] ^ p;
      chk((ch == 1) ? "preamble_R" : "preamble_L", 32'(got), 32'(pat));
      lvl = lev[b+7];
      bad = 1'b0;
      for (int s = 0; s < 28; s++) begin
        if (lev[b+8+2*s] == lvl) bad = 1'b1;
        w[s] = lev[b+8+2*s] ^ lev[b+9+2*s];
        lvl  = lev[b+9+2*s];
      end
      chk("bmc_transition", 32'(bad), 32'd0);
      chk((ch == 1) ? "audio_R" : "audio_L", 32'(w[23:0]), (ch == 1) ? 32'(e.r) : 32'(e.l));
      chk("validity", 32'(w[24]), 32'(e.v));
      chk("user_bit", 32'(w[25]), 32'd0);
      chk("chstat_bit", 32'(w[26]), 32'(cexp));
      chk("parity_even", 32'(^w), 32'd0);
      p = lev[b+63];
    end
    prev_lvl = p;
    frames_done++;
  endtask

  // Monitor: observes the edge just passed, then predicts the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc = 0; nxt = 0; fcnt = 0;
      tick_prev = 0; exp_ur = 0; exp_bs = 0; prev_lvl = 1'b0;
      pending.delete();
      expq.delete();
    end else begin
      longint sum;
      bit     tk;
      frame_t e;
      if (exp_ur || underrun)    chk("underrun_pulse", 32'(underrun), 32'(exp_ur));
      if (exp_bs || block_start) chk("block_start", 32'(block_start), 32'(exp_bs));
      if (tick_prev) begin
        lev[cap_idx] = spdif;
        if (cap_idx == 127) decode_frame(cap_frame);
      end
      sum = acc + 2 * BMCF;
      tk  = (sum >= CLKF);
      acc = tk ? sum - CLKF : sum;
      exp_ur = 0;
      exp_bs = 0;
      if (tk) begin
        cap_idx = nxt;
        if (nxt == 0) begin
          cap_frame = fcnt;
          exp_bs = ((fcnt % 192) == 0);
          if (pending.size() > 0) begin
            {e.l, e.r} = pending.pop_front();
            e.v = 1'b0;
          end else begin
            e = '0;
            e.v = 1'b1;
            exp_ur = 1;
          end
          expq.push_back(e);
          fcnt++;
        end
        nxt = (nxt == 127) ? 0 : nxt + 1;
      end
      if (sample_valid && sample_ready) pending.push_back({sample_left, sample_right});
      tick_prev = tk;
    end
  end

  task automatic offer(input logic [23:0] l, input logic [23:0] r);
    bit done;
    done = 0;
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (sample_ready) done = 1;
    end
    @(posedge clk);
    #2;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pair %h/%h not accepted, ready %b", l, r, sample_ready);
    end
  endtask

  task automatic wait_frames(input int f);
    for (int k = 0; k < 20000 && fcnt < f; k++) @(negedge clk);
    if (fcnt < f) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: reached boundary %0d, required %0d", fcnt, f);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_spdif", 32'(spdif), 32'd0);
    chk("reset_ready", 32'(sample_ready), 32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    chk("reset_block_start", 32'(block_start), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(sample_ready), 32'd1);

    // Accepted on the same edge as the first frame boundary: frame 0 underruns, frame 1 carries it.
    offer(24'h800001, 24'h7FFFFE);
    sample_valid = 1'b0;
    sample_left  = 24'hFFFFFF;
    sample_right = 24'h000000;
    chk("ready_low_when_full", 32'(sample_ready), 32'd0);
    wait_frames(2);
    chk("ready_after_boundary", 32'(sample_ready), 32'd1);

    for (int i = 0; i < 400 && fcnt < 195; i++)
      offer(24'(i * 32'h0001_0307) ^ 24'h5A5A5A, ~24'(i * 32'h0000_0B11));
    sample_valid = 1'b0;
    sample_left  = 24'h123456;
    sample_right = 24'h654321;
    wait_frames(fcnt + 2);

    for (int k = 0; k < 1000 && nxt != 95; k++) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_spdif", 32'(spdif), 32'd0);
    chk("midframe_reset_ready", 32'(sample_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rerelease", 32'(sample_ready), 32'd1);
    offer(24'h00F00F, 24'hC0FFEE);
    sample_valid = 1'b0;
    wait_frames(3);
    chk("frames_decoded_after_restart", 32'(frames_done >= 198), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/spdif_encode.md
SPDIF_ENCODE -- requirements
Module: spdif_encode

Interface
REQ-001 SHALL have parameter CLK_IN_FREQ, default 38400000, input clock frequency in Hz.
REQ-002 SHALL have parameter BMC_FREQ, default 3072000, S/PDIF bit-cell rate in Hz (64 x Fs).
REQ-003 SHALL have parameter CHSTAT_WORD, default 32'h0200_0004, channel-status bits 0..31, LSB first; used only when SPDIF_TX_CHSTAT_EN is defined.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sample_left  input  24  left audio sample, two's complement, MSB-aligned.
REQ-007 sample_right  input  24  right audio sample.
REQ-008 sample_valid  input  1  sample pair offered.
REQ-009 sample_ready  output  1  holding register empty; pair accepted on clk edge with sample_valid && sample_ready.
REQ-010 spdif  output  1  biphase-mark line output, driven directly from a flop.
REQ-011 underrun  output  1  one-cycle pulse when a frame starts with no pair held.
REQ-012 block_start  output  1  one-cycle pulse at the first half-cell of each Z preamble.

Function
REQ-013 Half-cell tick: phase accumulator adds 2*BMC_FREQ each clk; when sum >= CLK_IN_FREQ, subtract CLK_IN_FREQ and assert tick. Exact long-run rate, jitter <= 1 clk. Defaults: 128 ticks per 800 clk.
REQ-014 Line state advances only on tick; the spdif flop updates on the same clk as the tick.
REQ-015 Counters: half-cell 0..63 within subframe; channel flag (0 = left, 1 = right); frame 0..191; all wrap to 0.
REQ-016 Half-cells 0..7 carry the preamble. Z when left and frame == 0; X when left otherwise; Y when right.
REQ-017 Preamble patterns with line low before the preamble: X 11100010, Y 11100100, Z 11101000. When line is high before the preamble, the complement is sent.
REQ-018 Slots 4..31 are BMC-coded over half-cells 8..63, LSB first: 24 audio bits, V, U, C, P.
REQ-019 BMC coding: the first half-cell of each slot inverts the prior level. The second half-cell inverts again for a 1 and holds for a 0.
REQ-020 V = 0 when audio is real, 1 on underrun. U = 0.
REQ-021 P is chosen so that slots 4..31 contain an even number of ones; it is computed from the latched word.
REQ-022 At half-cell 0 of every left subframe (frame boundary):
  - if the holding register is full, latch both samples into the shift word, clear holding, V = 0 for both subframes;
  - otherwise transmit zero audio with V = 1 for both subframes and pulse underrun.
REQ-023 sample_ready = !holding_full, registered. If acceptance and frame-boundary load fall on the same clk, the load takes the old pair and the new pair lands in holding; neither pair is lost.
REQ-024 Latency: an accepted pair appears at the next frame boundary after acceptance; left audio LSB starts 8 half-cells later.
REQ-025 sample_left/right are sampled only on an accept edge; changes while not accepted are ignored.

Reset
REQ-026 While rst_n == 0: spdif = 0, sample_ready = 0, underrun = 0, block_start = 0; accumulator, counters and channel flag = 0; holding empty.
REQ-027 After release, sample_ready = 1 on the first clk. Transmission begins at the first tick with Z preamble, frame 0; underrun frames are sent until data arrives.
REQ-028 Reset asserted mid-subframe aborts immediately with no partial-frame completion; after release the block restarts at REQ-027.

Configuration
REQ-029 Macro SPDIF_TX_CHSTAT_EN:
  - defined: C in both subframes of frame n = CHSTAT_WORD[n] for n < 32, and 0 for n >= 32;
  - undefined: C = 0 always, and the CHSTAT_WORD logic is absent.

Verification
REQ-030 Reset release, no valid, 800 clk at defaults -> one frame: Z then Y, V = 1, audio 0, correct parity, one underrun pulse, one block_start.
REQ-031 Pair L = 24'h800001, R = 24'h7FFFFE before a boundary -> decoded slots match, V = 0, P even, ready high again 1 clk after the boundary.
REQ-032 Continuous valid for 193 frames -> Z exactly at frames 0 and 192, X elsewhere; no underrun after the first frame.
REQ-033 sample_valid asserted on the exact boundary clk -> old pair sent this frame, new pair sent next frame, no drop.
REQ-034 Loopback into spdif_decode for 256 random pairs -> identical samples out, fault = 0; with SPDIF_TX_CHSTAT_EN, C bits over frames 0..31 equal CHSTAT_WORD.
REQ-035 rst_n pulsed low at half-cell 30 of a right subframe -> spdif = 0 asynchronously; restart with Z after release.
